// File: rtl/uart_pkg.sv
// uart_pkg: shared UART frame types and baud divider rounding
package uart_pkg;
  typedef enum logic [1:0] {PAR_NONE, PAR_ODD, PAR_EVEN} uart_parity_e;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} uart_tx_state_e;
  function automatic int uart_div(input int clk_freq, input int baud);
    return (clk_freq + baud / 2) / baud;
  endfunction
endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous FIFO with wrap-bit pointers, occupancy and full flag
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         res_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             wdata,
  output logic [WIDTH-1:0]             rdata,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   level
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wptr, rptr;
  always_ff @(posedge clk or negedge res_n)
    if (!res_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      wptr <= wptr + PW'(push);
      rptr <= rptr + PW'(pop);
    end
  always_ff @(posedge clk)
    if (push) mem[wptr[AW-1:0]] <= wdata;
  assign rdata = mem[rptr[AW-1:0]];
  assign level = wptr - rptr;
  assign full  = wptr == {~rptr[AW], rptr[AW-1:0]};
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: UART transmitter with transmit FIFO, configurable framing and baud divider
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                                clk,
  input  logic                                res_n,
  input  logic [DATA_BITS-1:0]                data,
  input  logic                                wr,
  input  logic                                ovf_clr,
  output logic                                tx,
  output logic                                busy,
  output logic                                full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]     level,
  output logic                                overflow
);
  localparam int DIV = uart_div(CLK_FREQ, BAUD);
  localparam int CW  = $clog2(DIV);
  localparam int BW  = $clog2(DATA_BITS + 1);
  localparam int LW  = $clog2(FIFO_DEPTH + 1);
  localparam uart_parity_e PAR = uart_parity_e'(PARITY);
  if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 8 || PARITY < 0 || PARITY > 2 ||
      STOP_BITS < 1 || STOP_BITS > 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    $error("uart_tx_fifo: parameter out of range");
  end
  uart_tx_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DATA_BITS-1:0] sh_q, sh_d, rdata;
  logic par_q, par_d, tx_d, pop, push, tick;
  logic [LW-1:0] lvl_nxt;
  assign push = wr & ~full;
  assign tick = cnt_q == CW'(DIV - 1);
  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .res_n (res_n),
    .push  (push),
    .pop   (pop),
    .wdata (data),
    .rdata (rdata),
    .full  (full),
    .level (level)
  );
  // A pop from IDLE or from the last stop bit always lands in START with a fresh bit period.
  always_comb begin
    state_d = state_q;
    cnt_d   = (state_q == S_IDLE || tick) ? '0 : cnt_q + 1'b1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    par_d   = par_q;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE:   pop = level != '0;
      S_START:  if (tick) state_d = S_DATA;
      S_DATA:   if (tick) begin
        sh_d  = sh_q >> 1;
        bit_d = bit_q + 1'b1;
        if (bit_q == BW'(DATA_BITS - 1)) begin
          bit_d   = '0;
          state_d = PAR == PAR_NONE ? S_STOP : S_PARITY;
        end
      end
      S_PARITY: if (tick) state_d = S_STOP;
      S_STOP:   if (tick) begin
        bit_d = bit_q + 1'b1;
        if (bit_q == BW'(STOP_BITS - 1)) begin
          bit_d   = '0;
          state_d = S_IDLE;
          pop     = level != '0;
        end
      end
      default:  state_d = S_IDLE;
    endcase
    if (pop) begin
      state_d = S_START;
      sh_d    = rdata;
      par_d   = ^rdata ^ (PAR == PAR_ODD);
    end
    tx_d    = state_d == S_START ? 1'b0 : state_d == S_DATA ? sh_d[0] : state_d == S_PARITY ? par_d : 1'b1;
    lvl_nxt = level + LW'(push) - LW'(pop);
  end
  always_ff @(posedge clk or negedge res_n)
    if (!res_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      sh_q     <= '0;
      par_q    <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      sh_q     <= sh_d;
      par_q    <= par_d;
      tx       <= tx_d;
      busy     <= state_d != S_IDLE || lvl_nxt != '0;
      overflow <= (wr & full) | (overflow & ~ovf_clr);
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: 24 frame formats side by side, each checked every cycle against a frame-timeline model
module tb_uart_tx_fifo;
  localparam int N = 24;
  localparam int DIV = 10;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic res_n;
  logic [N-1:0] wr, ovf_clr, tx_o, busy_o, full_o, ovf_o;
  logic [7:0] din [N];
  logic [2:0] lvl_o [N];
  int vectors, miscompares;
  function automatic int cdb(int k);  return 5 + k / 6;       endfunction
  function automatic int csb(int k);  return 1 + (k / 3) % 2; endfunction
  function automatic int cpar(int k); return k % 3;           endfunction
  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int DB = cdb(g);
    uart_tx_fifo #(
      .CLK_FREQ(1_000_000), .BAUD(100_000), .DATA_BITS(DB),
      .PARITY(cpar(g)), .STOP_BITS(csb(g)), .FIFO_DEPTH(DEPTH)
    ) u_dut (
      .clk      (clk),
      .res_n    (res_n),
      .data     (din[g][DB-1:0]),
      .wr       (wr[g]),
      .ovf_clr  (ovf_clr[g]),
      .tx       (tx_o[g]),
      .busy     (busy_o[g]),
      .full     (full_o[g]),
      .level    (lvl_o[g]),
      .overflow (ovf_o[g])
    );
  end
  // Model: a queue of characters plus the bit pattern and elapsed cycles of the frame on the line.
  logic [7:0]  mq [N][$];
  bit          act [N];
  int          el [N];
  int          flen [N];
  logic [11:0] fb [N];
  bit          movf [N];
  function automatic logic [11:0] frame_bits(int k, logic [7:0] c);
    logic [11:0] v = '1;
    int db = cdb(k);
    int ones = $countones(c);
    v[0] = 1'b0;
    for (int i = 0; i < db; i++) v[1 + i] = c[i];
    if (cpar(k) != 0) v[1 + db] = cpar(k) == 2 ? ones[0] : ~ones[0];
    return v;
  endfunction
  function automatic int frame_len(int k);
    return 1 + cdb(k) + (cpar(k) != 0 ? 1 : 0) + csb(k);
  endfunction
  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      mq[k].delete();
      act[k] = 0;
      el[k] = 0;
      movf[k] = 0;
    end
  endtask
  task automatic model_step();
    for (int k = 0; k < N; k++) begin
      bit pf, done;
      pf = mq[k].size() == DEPTH;
      done = !act[k] || el[k] == flen[k] * DIV - 1;
      if (!done) el[k]++;
      else if (mq[k].size() != 0) begin
        fb[k] = frame_bits(k, mq[k].pop_front());
        flen[k] = frame_len(k);
        el[k] = 0;
        act[k] = 1;
      end else act[k] = 0;
      if (wr[k] && !pf) mq[k].push_back(din[k] & 8'((1 << cdb(k)) - 1));
      movf[k] = (wr[k] && pf) || (movf[k] && !ovf_clr[k]);
    end
  endtask
  task automatic compare();
    for (int k = 0; k < N; k++) begin
      logic ex_tx, ex_busy, ex_full;
      logic [2:0] ex_lvl;
      ex_tx = act[k] ? fb[k][el[k] / DIV] : 1'b1;
      ex_busy = act[k] || mq[k].size() != 0;
      ex_full = mq[k].size() == DEPTH;
      ex_lvl = 3'(mq[k].size());
      vectors++;
      if (tx_o[k] !== ex_tx || busy_o[k] !== ex_busy || full_o[k] !== ex_full ||
          lvl_o[k] !== ex_lvl || ovf_o[k] !== movf[k]) begin
        miscompares++;
        $display("FAIL cycle inst %0d t=%0t tx/busy/full/level/ovf got %b/%b/%b/%0d/%b want %b/%b/%b/%0d/%b",
                 k, $time, tx_o[k], busy_o[k], full_o[k], lvl_o[k], ovf_o[k],
                 ex_tx, ex_busy, ex_full, ex_lvl, movf[k]);
      end
    end
  endtask
  task automatic lit(string name, logic [31:0] got, logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask
  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic wr_one(int k, logic [7:0] d);
    din[k] = d;
    wr[k] = 1'b1;
    cyc(1);
    wr[k] = 1'b0;
  endtask
  // Samples the middle of every bit of one frame against a literal bit list (LSB = start bit).
  task automatic frame_chk(string name, int k, logic [7:0] d, logic [11:0] v, int n);
    wr_one(k, d);
    cyc(6);
    for (int i = 0; i < n; i++) begin
      lit($sformatf("%s bit %0d", name, i), 32'(tx_o[k]), 32'(v[i]));
      cyc(10);
    end
  endtask
  task automatic busy_len(string name, int k, logic [7:0] d, int want);
    int n = 0;
    wr_one(k, d);
    while (busy_o[k] && n < 1000) begin
      n++;
      cyc(1);
    end
    lit(name, n, want);
  endtask
  initial begin
    res_n = 1'b0;
    wr = '0;
    ovf_clr = '0;
    for (int k = 0; k < N; k++) din[k] = '0;
    vectors = 0;
    miscompares = 0;
    fork
      forever begin
        @(negedge clk);
        if (!res_n) model_reset();
        compare();
        if (res_n) model_step();
      end
      begin
        cyc(3);
        res_n = 1'b1;
        cyc(2);
        lit("reset tx", 32'(tx_o[18]), 1);
        lit("reset busy", 32'(busy_o), 0);
        lit("reset level", 32'(lvl_o[18]), 0);
        lit("reset full", 32'(full_o), 0);
        lit("reset overflow", 32'(ovf_o), 0);
        wr_one(18, 8'hA5);
        lit("8N1 level after E0", 32'(lvl_o[18]), 1);
        lit("8N1 busy after E0", 32'(busy_o[18]), 1);
        cyc(1);
        lit("8N1 level after pop", 32'(lvl_o[18]), 0);
        lit("8N1 tx after E1", 32'(tx_o[18]), 0);
        cyc(110);
        frame_chk("8N1 A5", 18, 8'hA5, {1'b1, 8'hA5, 1'b0}, 10);
        busy_len("8N1 busy cycles", 18, 8'hA5, 101);
        frame_chk("7E2 41", 17, 8'h41, {2'b11, 1'b0, 7'h41, 1'b0}, 11);
        busy_len("7E2 busy cycles", 17, 8'h41, 111);
        frame_chk("7O1 41", 13, 8'h41, {1'b1, 1'b1, 7'h41, 1'b0}, 10);
        cyc(5);
        for (int i = 1; i <= 6; i++) begin
          din[18] = 8'(i);
          wr[18] = 1'b1;
          cyc(1);
          if (i == 5) begin
            lit("burst level peak", 32'(lvl_o[18]), 4);
            lit("burst full", 32'(full_o[18]), 1);
          end
        end
        wr[18] = 1'b0;
        lit("burst overflow", 32'(ovf_o[18]), 1);
        lit("burst level after drop", 32'(lvl_o[18]), 4);
        begin
          int n = 0;
          while (busy_o[18] && n < 2000) begin
            n++;
            cyc(1);
          end
          lit("burst gapless busy", n, 496);
        end
        lit("overflow sticky", 32'(ovf_o[18]), 1);
        ovf_clr[18] = 1'b1;
        cyc(1);
        ovf_clr[18] = 1'b0;
        lit("overflow cleared", 32'(ovf_o[18]), 0);
        cyc(3);
        wr_one(18, 8'h11);
        for (int i = 0; i < 4; i++) wr_one(18, 8'(8'h20 + i));
        lit("full before stop end", 32'(full_o[18]), 1);
        cyc(96);
        wr_one(18, 8'h99);
        lit("drop-on-pop level", 32'(lvl_o[18]), 3);
        lit("drop-on-pop overflow", 32'(ovf_o[18]), 1);
        lit("drop-on-pop full", 32'(full_o[18]), 0);
        cyc(450);
        ovf_clr[18] = 1'b1;
        cyc(1);
        ovf_clr[18] = 1'b0;
        wr_one(18, 8'h33);
        cyc(33);
        #1 res_n = 1'b0;
        #1;
        lit("abort tx", 32'(tx_o[18]), 1);
        lit("abort busy", 32'(busy_o[18]), 0);
        lit("abort level", 32'(lvl_o[18]), 0);
        cyc(2);
        res_n = 1'b1;
        cyc(2);
        frame_chk("post-reset 55", 18, 8'h55, {1'b1, 8'h55, 1'b0}, 10);
        repeat (3000) begin
          for (int k = 0; k < N; k++) begin
            wr[k] = $urandom_range(0, 99) < 3;
            din[k] = 8'($urandom);
            ovf_clr[k] = $urandom_range(0, 199) == 0;
          end
          cyc(1);
        end
        wr = '0;
        ovf_clr = '0;
        cyc(1500);
        lit("sweep drained", 32'(busy_o), 0);
      end
    join_any
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo.md
# uart_tx_fifo

Parametrised UART transmitter with an internal transmit FIFO, configurable frame format and an integrated baud divider. It replaces the fixed 7-bit, single-byte transmit path of the SoC debug/console UART. Software or a bus adapter can queue several characters without polling `busy` per byte. It sits between the peripheral bus write strobe and the `tx` pad.

## Interface
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `BAUD`, 115200: line rate; `DIV = (CLK_FREQ + BAUD/2) / BAUD`, must be ≥ 2.
- `DATA_BITS`, 8: data bits per frame, 5..8.
- `PARITY`, 0: 0 = none, 1 = odd, 2 = even.
- `STOP_BITS`, 1: 1 or 2.
- `FIFO_DEPTH`, 8: entries, power of two, ≥ 2.

Ports:
- `clk`  in  1  system clock.
- `res_n`  in  1  reset; asynchronous, active-low.
- `data`  in  DATA_BITS  character to queue.
- `wr`  in  1  write strobe, one character per cycle high.
- `ovf_clr`  in  1  clears `overflow`.
- `tx`  out  1  serial line, idle high.
- `busy`  out  1  high while FIFO non-empty or a frame is in progress.
- `full`  out  1  FIFO holds FIFO_DEPTH entries.
- `level`  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy.
- `overflow`  out  1  sticky; set when `wr` is dropped.

## Operation
- Reset: `tx`=1, `busy`=0, `full`=0, `level`=0, `overflow`=0, FIFO emptied, FSM in IDLE, baud counter 0. Assertion mid-frame aborts the frame immediately; no partial character resumes.
- Write: `wr` with `full`=0 pushes `data`. `wr` with `full`=1 is dropped and sets `overflow`, even if a pop occurs in the same cycle (`full` is the registered value).
- `ovf_clr` and a dropped write in the same cycle: `overflow` ends set.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: FIFO non-empty → pop head into shift register, go to START.
  - START: `tx`=0 for DIV cycles → DATA.
  - DATA: LSB first, DATA_BITS bits, DIV cycles each → PARITY if PARITY≠0, else STOP.
  - PARITY: odd/even over the DATA_BITS data bits only → STOP.
  - STOP: `tx`=1 for STOP_BITS×DIV cycles. At the end: FIFO non-empty → pop and go directly to START, with no idle cycle. Otherwise → IDLE.
- Baud counter runs only outside IDLE and restarts at 0 on every entry to START, so each bit is exactly DIV cycles.
- Bit counter width: $clog2(DATA_BITS+1). Unused high bits of the shift register are ignored.
- `busy` = (state≠IDLE) | (level≠0), registered.

## Timing
- `wr` sampled at edge E0 into an empty FIFO with FSM idle: `level`=1 after E0. Pop at E1: `tx` falls after E1 and `level` returns to 0.
- Frame length: (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) × DIV cycles.
- Back-to-back: the next start bit begins on the cycle after the last stop-bit cycle.
- Simultaneous push and pop: `level` unchanged.
- `busy` falls on the edge after the final stop-bit cycle when the FIFO is empty.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package `uart_pkg`:
  - `uart_parity_e` enum (NONE, ODD, EVEN).
  - `uart_tx_state_e` enum.
  - Function `uart_div(clk_freq, baud)` for DIV rounding, reused by the existing clock generator and a future receiver.
- Sub-module `uart_fifo`:
  - Parametrised WIDTH/DEPTH synchronous FIFO.
  - Pointers one bit wider than address for full/empty.
  - Outputs `level` and `full`.
- Top holds the baud counter, bit counter, shift register and FSM. Elaboration-time assertions check the parameter ranges.

## Test plan
Bench parameters: CLK_FREQ=1_000_000, BAUD=100_000, so DIV=10.
- 8N1, single write of 0xA5 from idle → `tx` low after E1 for 10 cycles, then bits 1,0,1,0,0,1,0,1 at 10 cycles each, then high 10 cycles. `busy` high for 101 cycles total.
- 7E2, write 0x41 → parity bit 0, two stop bits; frame = 110 cycles. 7O1, write 0x41 → parity bit 1.
- FIFO_DEPTH=4, 6 writes on consecutive cycles during idle (0x01..0x06):
  - first is popped at E1, so 0x01..0x05 are accepted and `level` peaks at 4;
  - 6th write dropped, `overflow`=1;
  - five frames transmitted with no idle gap;
  - `ovf_clr` then clears `overflow`.
- Write while `level`=FIFO_DEPTH and a stop bit is ending (pop same cycle) → write dropped, `overflow` set, `level` becomes FIFO_DEPTH-1.
- `res_n` asserted during the 3rd data bit → `tx`=1, `busy`=0, `level`=0 immediately. After release, a new write of 0x55 transmits a clean full frame.
- Parameter sweep: DATA_BITS 5..8 × STOP_BITS 1..2 × PARITY 0..2 → scoreboard decodes every frame and matches the written data.
